// File: rtl/tile_walker.sv
// Raster walker over an inclusive tile bounding box that carries three edge functions along.
// Optional trivial-reject of tiles fully outside an edge: define TILE_WALKER_REJECT_EN.
module tile_walker #(
  parameter int TILE_SHIFT = 5
) (
  input  logic        gpu_clk,
  input  logic        gpu_resetn,
  input  logic        start,
  input  logic [5:0]  tx0,
  input  logic [5:0]  ty0,
  input  logic [5:0]  tx1,
  input  logic [5:0]  ty1,
  input  logic [18:0] A01_in,
  input  logic [18:0] A12_in,
  input  logic [18:0] A20_in,
  input  logic [23:0] B01_in,
  input  logic [23:0] B12_in,
  input  logic [23:0] B20_in,
  input  logic [31:0] w0_in,
  input  logic [31:0] w1_in,
  input  logic [31:0] w2_in,
  output logic        tile_valid,
  input  logic        tile_ready,
  output logic [5:0]  tile_x,
  output logic [5:0]  tile_y,
  output logic [31:0] tile_w0,
  output logic [31:0] tile_w1,
  output logic [31:0] tile_w2,
  output logic        busy,
  output logic        done,
  output logic [11:0] tile_count
);

  typedef enum logic [2:0] {IDLE, EVAL, EMIT, STEP, FIN} state_t;

  state_t state_reg, state_next;

  logic [5:0]        tx_reg, ty_reg, tx0_reg, tx1_reg, ty1_reg;
  logic [2:0][31:0]  a_ext_reg, b_ext_reg, row_w_reg, cur_w_reg;
  logic [11:0]       tile_count_reg;
  logic              done_reg;

  logic [2:0][18:0]  a_raw;
  logic [2:0][23:0]  b_raw;
  logic [2:0][31:0]  w_in_vec, a_ext_in, b_ext_in;
  logic [2:0][31:0]  a_step, b_step, row_w_next, cur_w_next;
  logic [2:0]        edge_out;
  logic              reject, box_empty, last_col, last_tile;

  assign a_raw    = {A20_in, A12_in, A01_in};
  assign b_raw    = {B20_in, B12_in, B01_in};
  assign w_in_vec = {w2_in, w1_in, w0_in};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign a_ext_in[gi]   = {{13{a_raw[gi][18]}}, a_raw[gi]};
      assign b_ext_in[gi]   = {{8{b_raw[gi][23]}}, b_raw[gi]};
      assign a_step[gi]     = a_ext_reg[gi] << TILE_SHIFT;
      assign b_step[gi]     = b_ext_reg[gi] << TILE_SHIFT;
      assign row_w_next[gi] = row_w_reg[gi] + b_step[gi];
      assign cur_w_next[gi] = cur_w_reg[gi] + a_step[gi];
`ifdef TILE_WALKER_REJECT_EN
      // Far corners sit (2^TILE_SHIFT - 1) pixels away: step minus one unit step.
      logic [31:0] c_a, c_b, c_ab;
      assign c_a  = cur_w_reg[gi] + a_step[gi] - a_ext_reg[gi];
      assign c_b  = cur_w_reg[gi] + b_step[gi] - b_ext_reg[gi];
      assign c_ab = c_a + b_step[gi] - b_ext_reg[gi];
      assign edge_out[gi] = cur_w_reg[gi][31] & c_a[31] & c_b[31] & c_ab[31];
`else
      assign edge_out[gi] = 1'b0;
`endif
    end
  endgenerate

  assign reject    = |edge_out;
  assign box_empty = (tx1 < tx0) || (ty1 < ty0);
  assign last_col  = (tx_reg == tx1_reg);
  assign last_tile = last_col && (ty_reg == ty1_reg);

  always_ff @(posedge gpu_clk or negedge gpu_resetn) begin
    if (!gpu_resetn) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = box_empty ? FIN : EVAL;
      EVAL:    state_next = reject ? STEP : EMIT;
      EMIT:    if (tile_ready) state_next = STEP;
      STEP:    state_next = last_tile ? FIN : EVAL;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge gpu_clk or negedge gpu_resetn) begin
    if (!gpu_resetn) begin
      tx_reg         <= '0;
      ty_reg         <= '0;
      tx0_reg        <= '0;
      tx1_reg        <= '0;
      ty1_reg        <= '0;
      a_ext_reg      <= '0;
      b_ext_reg      <= '0;
      row_w_reg      <= '0;
      cur_w_reg      <= '0;
      tile_count_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      // Registered so the pulse lands one cycle after FIN, with the block already idle.
      done_reg <= (state_reg == FIN);
      case (state_reg)
        IDLE: begin
          if (start) begin
            tx0_reg        <= tx0;
            tx1_reg        <= tx1;
            ty1_reg        <= ty1;
            tx_reg         <= tx0;
            ty_reg         <= ty0;
            a_ext_reg      <= a_ext_in;
            b_ext_reg      <= b_ext_in;
            row_w_reg      <= w_in_vec;
            cur_w_reg      <= w_in_vec;
            tile_count_reg <= '0;
          end
        end
        EMIT: begin
          if (tile_ready) tile_count_reg <= tile_count_reg + 12'd1;
        end
        STEP: begin
          if (!last_tile) begin
            if (last_col) begin
              tx_reg    <= tx0_reg;
              ty_reg    <= ty_reg + 6'd1;
              row_w_reg <= row_w_next;
              cur_w_reg <= row_w_next;
            end else begin
              tx_reg    <= tx_reg + 6'd1;
              cur_w_reg <= cur_w_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tile_valid = (state_reg == EMIT);
  assign busy       = (state_reg != IDLE);
  assign done       = done_reg;
  assign tile_x     = tx_reg;
  assign tile_y     = ty_reg;
  assign tile_w0    = cur_w_reg[0];
  assign tile_w1    = cur_w_reg[1];
  assign tile_w2    = cur_w_reg[2];
  assign tile_count = tile_count_reg;

endmodule

// File: tb/tb_tile_walker.sv
// Scoreboard bench for tile_walker: stimulus pushes expected tiles, a monitor pops on handshake.
module tb_tile_walker;

  logic        gpu_clk, gpu_resetn, start;
  logic [5:0]  tx0, ty0, tx1, ty1;
  logic [18:0] A01_in, A12_in, A20_in;
  logic [23:0] B01_in, B12_in, B20_in;
  logic [31:0] w0_in, w1_in, w2_in;
  logic        tile_valid, tile_ready, busy, done;
  logic [5:0]  tile_x, tile_y;
  logic [31:0] tile_w0, tile_w1, tile_w2;
  logic [11:0] tile_count;

  typedef struct {
    logic [5:0]  x, y;
    logic [31:0] w0, w1, w2;
  } tile_t;

  tile_t exp_q[$];
  tile_t mon_e;
  int    checks = 0;
  int    errors = 0;
  int    done_seen = 0;

  tile_walker #(.TILE_SHIFT(5)) dut (
    .gpu_clk(gpu_clk), .gpu_resetn(gpu_resetn), .start(start),
    .tx0(tx0), .ty0(ty0), .tx1(tx1), .ty1(ty1),
    .A01_in(A01_in), .A12_in(A12_in), .A20_in(A20_in),
    .B01_in(B01_in), .B12_in(B12_in), .B20_in(B20_in),
    .w0_in(w0_in), .w1_in(w1_in), .w2_in(w2_in),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_x(tile_x), .tile_y(tile_y),
    .tile_w0(tile_w0), .tile_w1(tile_w1), .tile_w2(tile_w2),
    .busy(busy), .done(done), .tile_count(tile_count)
  );

  initial gpu_clk = 1'b0;
  always #5 gpu_clk = ~gpu_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Monitor: a handshake completes at the next rising edge, so sample on the falling edge.
  always @(negedge gpu_clk) begin
    if (gpu_resetn && done) done_seen++;
    if (gpu_resetn && tile_valid && tile_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tile: got (%0d,%0d) w0=%h required none", tile_x, tile_y, tile_w0);
      end else begin
        mon_e = exp_q.pop_front();
        if (tile_x !== mon_e.x || tile_y !== mon_e.y || tile_w0 !== mon_e.w0 ||
            tile_w1 !== mon_e.w1 || tile_w2 !== mon_e.w2) begin
          errors++;
          $display("FAIL tile: got (%0d,%0d) %h %h %h required (%0d,%0d) %h %h %h",
                   tile_x, tile_y, tile_w0, tile_w1, tile_w2,
                   mon_e.x, mon_e.y, mon_e.w0, mon_e.w1, mon_e.w2);
        end else begin
          $display("tile (%0d,%0d) w0=%h w1=%h w2=%h", tile_x, tile_y, tile_w0, tile_w1, tile_w2);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  task automatic push(input logic [5:0] x, input logic [5:0] y,
                      input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    tile_t t;
    t.x = x; t.y = y; t.w0 = w0; t.w1 = w1; t.w2 = w2;
    exp_q.push_back(t);
  endtask

  task automatic set_box(input logic [5:0] x0, input logic [5:0] y0,
                         input logic [5:0] x1, input logic [5:0] y1);
    tx0 = x0; ty0 = y0; tx1 = x1; ty1 = y1;
  endtask

  task automatic set_edges(input logic [18:0] a0, input logic [18:0] a1, input logic [18:0] a2,
                           input logic [23:0] b0, input logic [23:0] b1, input logic [23:0] b2,
                           input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    A01_in = a0; A12_in = a1; A20_in = a2;
    B01_in = b0; B12_in = b1; B20_in = b2;
    w0_in = v0; w1_in = v1; w2_in = v2;
  endtask

  // Returns at 1 time unit after the edge that sampled start.
  task automatic pulse_start();
    @(posedge gpu_clk); #1;
    start = 1'b1;
    @(posedge gpu_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    bit seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge gpu_clk);
      if (tile_valid) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s: got no tile_valid required tile_valid within %0d cycles", name, max_cycles);
    end
  endtask

  task automatic wait_done(input string name, input int max_cycles, input logic [11:0] req_count);
    int d0 = done_seen;
    bit seen = 0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge gpu_clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_done: got no done required done within %0d cycles", name, max_cycles);
    end else begin
      chk({name, "_count"}, {20'd0, tile_count}, {20'd0, req_count});
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      @(negedge gpu_clk);
      chk({name, "_done_once"}, done_seen - d0, 32'd1);
      chk({name, "_done_drop"}, {31'd0, done}, 32'd0);
      chk({name, "_queue_empty"}, exp_q.size(), 32'd0);
    end
  endtask

  initial begin
    gpu_resetn = 1'b0;
    start = 1'b0;
    tile_ready = 1'b1;
    set_box(6'd0, 6'd0, 6'd0, 6'd0);
    set_edges('0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) @(negedge gpu_clk);
    chk("rst_valid", {31'd0, tile_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_count", {20'd0, tile_count}, 32'd0);
    chk("rst_w0", tile_w0, 32'd0);
    @(posedge gpu_clk); #1;
    gpu_resetn = 1'b1;

    // 2x2 box, uniform steps: raster order with row step 0x2000 and column step 32.
    set_box(6'd0, 6'd0, 6'd1, 6'd1);
    set_edges(19'd1, 19'd1, 19'd1, 24'h100, 24'h100, 24'h100, 32'd0, 32'd0, 32'd0);
    push(6'd0, 6'd0, 32'h0,    32'h0,    32'h0);
    push(6'd1, 6'd0, 32'h20,   32'h20,   32'h20);
    push(6'd0, 6'd1, 32'h2000, 32'h2000, 32'h2000);
    push(6'd1, 6'd1, 32'h2020, 32'h2020, 32'h2020);
    pulse_start();
    wait_done("box2x2", 50, 12'd4);

    // Empty box: done two cycles after start, no tiles, count cleared.
    set_box(6'd3, 6'd0, 6'd2, 6'd0);
    pulse_start();
    @(negedge gpu_clk);
    chk("empty_fin_done", {31'd0, done}, 32'd0);
    chk("empty_fin_busy", {31'd0, busy}, 32'd1);
    @(negedge gpu_clk);
    chk("empty_done", {31'd0, done}, 32'd1);
    chk("empty_busy", {31'd0, busy}, 32'd0);
    chk("empty_count", {20'd0, tile_count}, 32'd0);
    @(negedge gpu_clk);
    chk("empty_done_drop", {31'd0, done}, 32'd0);

    // Backpressure on first tile; also negative step and wrap past 0x7fffffff.
    tile_ready = 1'b0;
    set_box(6'd2, 6'd1, 6'd3, 6'd1);
    set_edges(19'h7FFFD, 19'h3FFFF, 19'd1, 24'd7, 24'd7, 24'd7,
              32'd1000, 32'd5, 32'h7FFFFFF0);
    push(6'd2, 6'd1, 32'd1000, 32'd5,       32'h7FFFFFF0);
    push(6'd3, 6'd1, 32'd904,  32'd8388581, 32'h80000010);
    pulse_start();
    @(negedge gpu_clk);
    chk("lat_eval_valid", {31'd0, tile_valid}, 32'd0);
    chk("lat_eval_busy", {31'd0, busy}, 32'd1);
    @(negedge gpu_clk);
    chk("lat_emit_valid", {31'd0, tile_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge gpu_clk);
      chk("stall_valid", {31'd0, tile_valid}, 32'd1);
      chk("stall_x", {26'd0, tile_x}, 32'd2);
      chk("stall_w0", tile_w0, 32'd1000);
      chk("stall_count", {20'd0, tile_count}, 32'd0);
    end
    @(posedge gpu_clk); #1;
    tile_ready = 1'b1;
    @(negedge gpu_clk);
    @(negedge gpu_clk);
    chk("stall_count_after", {20'd0, tile_count}, 32'd1);
    wait_done("stall", 50, 12'd2);

    // Second start mid-walk with different inputs must be ignored.
    set_box(6'd0, 6'd0, 6'd1, 6'd1);
    set_edges(19'd2, 19'd0, 19'h40000, 24'hFFFFFF, 24'd1, 24'd0,
              32'd0, 32'd100, 32'd0);
    push(6'd0, 6'd0, 32'h0,        32'd100, 32'h0);
    push(6'd1, 6'd0, 32'd64,       32'd100, 32'hFF800000);
    push(6'd0, 6'd1, 32'hFFFFFFE0, 32'd132, 32'h0);
    push(6'd1, 6'd1, 32'd32,       32'd132, 32'hFF800000);
    pulse_start();
    repeat (3) @(posedge gpu_clk);
    #1;
    set_box(6'd5, 6'd5, 6'd9, 6'd9);
    set_edges(19'd9, 19'd9, 19'd9, 24'd9, 24'd9, 24'd9, 32'd9, 32'd9, 32'd9);
    start = 1'b1;
    @(posedge gpu_clk); #1;
    start = 1'b0;
    wait_done("restart_ignored", 60, 12'd4);

    // Reset while tile 2 of 4 is being presented.
    tile_ready = 1'b0;
    set_box(6'd0, 6'd0, 6'd3, 6'd0);
    set_edges(19'd1, 19'd1, 19'd1, 24'd0, 24'd0, 24'd0, 32'd0, 32'd0, 32'd0);
    push(6'd0, 6'd0, 32'h0, 32'h0, 32'h0);
    pulse_start();
    wait_valid("rst_walk_t0", 20);
    @(posedge gpu_clk); #1;
    tile_ready = 1'b1;
    @(posedge gpu_clk); #1;
    tile_ready = 1'b0;
    wait_valid("rst_walk_t1", 20);
    chk("rst_walk_t1_x", {26'd0, tile_x}, 32'd1);
    @(posedge gpu_clk); #1;
    gpu_resetn = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, tile_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_x", {26'd0, tile_x}, 32'd0);
    chk("midrst_w0", tile_w0, 32'd0);
    chk("midrst_count", {20'd0, tile_count}, 32'd0);
    chk("midrst_queue", exp_q.size(), 32'd0);
    repeat (2) @(posedge gpu_clk);
    #1;
    gpu_resetn = 1'b1;
    tile_ready = 1'b1;
    set_box(6'd0, 6'd0, 6'd1, 6'd0);
    push(6'd0, 6'd0, 32'h0,  32'h0,  32'h0);
    push(6'd1, 6'd0, 32'h20, 32'h20, 32'h20);
    pulse_start();
    wait_done("after_rst", 40, 12'd2);

    // Edge 0 stays negative over tiles 0-2; tile 3 reaches non-negative corners.
    set_box(6'd0, 6'd0, 6'd3, 6'd0);
    set_edges(19'd1, 19'd1, 19'd1, 24'd0, 24'd0, 24'd0,
              32'hFFFFFF9C, 32'd1000000, 32'd1000000);
`ifdef TILE_WALKER_REJECT_EN
    push(6'd3, 6'd0, 32'hFFFFFFFC, 32'd1000096, 32'd1000096);
    pulse_start();
    wait_done("reject", 60, 12'd1);
`else
    push(6'd0, 6'd0, 32'hFFFFFF9C, 32'd1000000, 32'd1000000);
    push(6'd1, 6'd0, 32'hFFFFFFBC, 32'd1000032, 32'd1000032);
    push(6'd2, 6'd0, 32'hFFFFFFDC, 32'd1000064, 32'd1000064);
    push(6'd3, 6'd0, 32'hFFFFFFFC, 32'd1000096, 32'd1000096);
    pulse_start();
    wait_done("noreject", 60, 12'd4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
